pn_fork_sink: RTL and testbench

//  Downstream consumer for a Petri-net output place (avail/take handshake: avail = token present, take = consume).

---
 rtl/pn_pkg.sv | 23 ++
 rtl/pn_place.sv | 28 ++
 rtl/pn_fork_sink.sv | 84 ++++++++
 tb/tb_pn_fork_sink.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/pn_pkg.sv
// ============================================================================
// pn_pkg : shared Petri-net place types and the 1-safe place update rule
// Revision: 1.0
// ============================================================================
`default_nettype none

package pn_pkg;

  typedef logic pn_tok_t;

  // A deposit wins over a take on the same edge, which is what lets an
  // output place be refilled while it is being drained.
  function automatic pn_tok_t pn_place_next(input pn_tok_t avail,
                                            input logic    deposit,
                                            input logic    take);
    if (deposit)   return 1'b1;
    else if (take) return 1'b0;
    else           return avail;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pn_place.sv
// ============================================================================
// pn_place : 1-safe place register with deposit/take handshake
// Revision: 1.0
// ============================================================================
`default_nettype none

module pn_place
  import pn_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    i_deposit,
  input  logic    i_take,
  output pn_tok_t o_avail
);

  pn_tok_t r_avail;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_avail <= 1'b0;
    else     r_avail <= pn_place_next(r_avail, i_deposit, i_take);
  end

  assign o_avail = r_avail;

endmodule

`default_nettype wire

// File: rtl/pn_fork_sink.sv
// ============================================================================
// pn_fork_sink : pulls tokens into a bounded counting place and forks each
//                one into two 1-safe output places
// Revision: 1.0
// ============================================================================
`default_nettype none

module pn_fork_sink
  import pn_pkg::*;
#(
  parameter int CAPACITY    = 4,
  parameter int CNT_W       = $clog2(CAPACITY + 1),
  parameter int INIT_TOKENS = 0,
  parameter int STAT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_tok_in_avail,
  output logic              o_tok_in_take,
  output logic              o_out_a_avail,
  input  logic              i_out_a_take,
  output logic              o_out_b_avail,
  input  logic              i_out_b_take,
  output logic [CNT_W-1:0]  o_tok_count,
  output logic [STAT_W-1:0] o_fork_count
);

  localparam logic [CNT_W-1:0] c_CAP  = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] c_INIT = CNT_W'(INIT_TOKENS);

  logic [CNT_W-1:0]  r_count;
  logic [STAT_W-1:0] r_forks;
  pn_tok_t           w_a_avail;
  pn_tok_t           w_b_avail;
  logic              w_free_a;
  logic              w_free_b;
  logic              w_fork;
  logic              w_take;

  assign w_free_a = !w_a_avail || i_out_a_take;
  assign w_free_b = !w_b_avail || i_out_b_take;
  assign w_fork   = (r_count != '0) && w_free_a && w_free_b;
  // A fork on this edge frees a slot, so a full place may still accept.
  assign w_take   = !rst && i_tok_in_avail && ((r_count < c_CAP) || w_fork);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= c_INIT;
      r_forks <= '0;
    end else begin
      case ({w_take, w_fork})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_fork) r_forks <= r_forks + STAT_W'(1);
    end
  end

  pn_place u_place_a (
    .clk       (clk),
    .rst       (rst),
    .i_deposit (w_fork),
    .i_take    (i_out_a_take),
    .o_avail   (w_a_avail)
  );

  pn_place u_place_b (
    .clk       (clk),
    .rst       (rst),
    .i_deposit (w_fork),
    .i_take    (i_out_b_take),
    .o_avail   (w_b_avail)
  );

  assign o_tok_in_take = w_take;
  assign o_out_a_avail = w_a_avail;
  assign o_out_b_avail = w_b_avail;
  assign o_tok_count   = r_count;
  assign o_fork_count  = r_forks;

endmodule

`default_nettype wire

// File: tb/tb_pn_fork_sink.sv
// ============================================================================
// tb_pn_fork_sink : directed and random checks of pn_fork_sink against a
//                   token-counting reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pn_fork_sink;

  localparam int CAP    = 4;
  localparam int CNT_W  = $clog2(CAP + 1);
  localparam int STAT_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_tok_in_avail = 1'b0;
  logic              o_tok_in_take;
  logic              o_out_a_avail;
  logic              i_out_a_take = 1'b0;
  logic              o_out_b_avail;
  logic              i_out_b_take = 1'b0;
  logic [CNT_W-1:0]  o_tok_count;
  logic [STAT_W-1:0] o_fork_count;

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_cnt   = 0;
  int m_a     = 0;
  int m_b     = 0;
  int m_forks = 0;

  always #5 clk = ~clk;

  pn_fork_sink #(
    .CAPACITY    (CAP),
    .INIT_TOKENS (0),
    .STAT_W      (STAT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_tok_in_avail (i_tok_in_avail),
    .o_tok_in_take  (o_tok_in_take),
    .o_out_a_avail  (o_out_a_avail),
    .i_out_a_take   (i_out_a_take),
    .o_out_b_avail  (o_out_b_avail),
    .i_out_b_take   (i_out_b_take),
    .o_tok_count    (o_tok_count),
    .o_fork_count   (o_fork_count)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".count"}, int'(o_tok_count), m_cnt);
    chk({tag, ".a"}, int'(o_out_a_avail), m_a);
    chk({tag, ".b"}, int'(o_out_b_avail), m_b);
    chk({tag, ".forks"}, int'(o_fork_count), m_forks);
  endtask

  // One clock: drive inputs at a negedge, check take, apply edge, check state.
  task automatic cycle(input string tag, input logic av, input logic ta, input logic tb);
    int e_fork;
    int e_take;
    i_tok_in_avail = av;
    i_out_a_take   = ta;
    i_out_b_take   = tb;
    e_fork = (m_cnt > 0 && (m_a == 0 || ta) && (m_b == 0 || tb)) ? 1 : 0;
    e_take = (av && (m_cnt < CAP || e_fork == 1)) ? 1 : 0;
    #1;
    chk({tag, ".take"}, int'(o_tok_in_take), e_take);
    @(posedge clk);
    m_cnt = m_cnt + e_take - e_fork;
    if (e_fork == 1) begin
      m_a = 1;
      m_b = 1;
      m_forks = (m_forks + 1) % (1 << STAT_W);
    end else begin
      if (ta) m_a = 0;
      if (tb) m_b = 0;
    end
    @(negedge clk);
    chk_state(tag);
  endtask

  // Asynchronous reset pulse; outputs must clear before any clock edge.
  task automatic pulse_reset(input string tag);
    i_tok_in_avail = 1'b1;
    i_out_a_take   = 1'b0;
    i_out_b_take   = 1'b0;
    #2 rst = 1'b1;
    #1;
    m_cnt = 0; m_a = 0; m_b = 0; m_forks = 0;
    chk_state(tag);
    chk({tag, ".take"}, int'(o_tok_in_take), 0);
    @(negedge clk);
    chk({tag, ".take_held"}, int'(o_tok_in_take), 0);
    rst = 1'b0;
    i_tok_in_avail = 1'b0;
  endtask

  initial begin
    // 1: reset state
    @(negedge clk);
    chk_state("reset");
    chk("reset.take", int'(o_tok_in_take), 0);
    rst = 1'b0;

    // 2: single token, two-edge latency
    cycle("single1", 1'b1, 1'b0, 1'b0);
    chk("single1.cnt_const", int'(o_tok_count), 1);
    cycle("single2", 1'b0, 1'b0, 1'b0);
    chk("single2.a_const", int'(o_out_a_avail), 1);
    chk("single2.forks_const", int'(o_fork_count), 1);

    // 3: fill to capacity with stalled outputs, then release
    pulse_reset("rst3");
    for (int i = 0; i < 6; i++) cycle("fill", 1'b1, 1'b0, 1'b0);
    chk("full.cnt_const", int'(o_tok_count), CAP);
    chk("full.take_const", int'(o_tok_in_take), 0);
    cycle("full_hold", 1'b1, 1'b0, 1'b0);
    cycle("full_release", 1'b1, 1'b1, 1'b1);
    chk("full_release.cnt_const", int'(o_tok_count), CAP);

    // 4: streaming, one fork per cycle, fork_count wraps
    pulse_reset("rst4");
    for (int i = 0; i < 20; i++) cycle("stream", 1'b1, 1'b1, 1'b1);
    chk("stream.cnt_const", int'(o_tok_count), 1);
    chk("stream.forks_const", int'(o_fork_count), 19 % 16);

    // 5: only A consumed -> fork blocked until B taken
    pulse_reset("rst5");
    cycle("ab1", 1'b1, 1'b0, 1'b0);
    cycle("ab2", 1'b1, 1'b0, 1'b0);
    cycle("ab3", 1'b1, 1'b1, 1'b0);
    cycle("ab4", 1'b1, 1'b0, 1'b0);
    chk("ab4.a_const", int'(o_out_a_avail), 0);
    chk("ab4.b_const", int'(o_out_b_avail), 1);
    cycle("ab5", 1'b0, 1'b0, 1'b1);
    chk("ab5.a_const", int'(o_out_a_avail), 1);

    // 6: async reset mid-stream with count=3, A=B=1
    pulse_reset("rst6a");
    for (int i = 0; i < 4; i++) cycle("mid", 1'b1, 1'b0, 1'b0);
    chk("mid.cnt_const", int'(o_tok_count), 3);
    pulse_reset("rst6b");

    // random traffic against the model
    for (int i = 0; i < 400; i++)
      cycle("rand", logic'($urandom_range(0, 1)),
            logic'(($urandom % 4) != 0), logic'(($urandom % 4) != 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
